vertex_transform_mmap: RTL and testbench

//  Memory-mapped affine vertex transform engine on the 16-bit system BUS: out = M*v + t, Q8.8 signed.
//  CPU writes the 3x3 matrix, translation and N_VERT input vertices, then writes CTRL.start.
//  One shared multiply-accumulate, sequenced by an FSM, writes N_VERT output vertices.

---
 rtl/vertex_transform_mmap.sv | 217 +++++++++++++++++++++
 tb/tb_vertex_transform_mmap.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_transform_mmap.sv
// Memory-mapped affine vertex transform, out = M*v + t in signed fixed point, one shared MAC.
// Latency: read data 1 cycle after address; done rises 12*N_VERT+1 cycles after the start write.
// Backpressure: none; M/t/VIN writes and start are dropped while busy. Optional clamp: SATURATE_EN.
module vertex_transform_mmap #(
    parameter int BASE      = 0,
    parameter int N_VERT    = 4,
    parameter int FRAC_BITS = 8
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    inout  wire  [15:0] BUS,
    input  logic [31:0] address,
    input  logic        writeEn,
    input  logic        outputEn,
    output logic        irq
);

    localparam int NW = 3 * N_VERT;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [31:0] VIN_LO  = 32'd16;
    localparam logic [31:0] VOUT_LO = 32'(16 + NW);
    localparam logic [31:0] VOUT_HI = 32'(16 + 2 * NW);

    typedef enum logic [2:0] {
        S_IDLE, S_ACC0, S_ACC1, S_ACC2, S_STORE, S_DONE
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_vert;
    logic [1:0]         r_comp;
    logic signed [35:0] r_acc;
    logic [15:0]        r_rdata;
    logic [15:0]        r_m    [0:8];
    logic [15:0]        r_t    [0:2];
    logic [15:0]        r_vin  [0:NW-1];
    logic [15:0]        r_vout [0:NW-1];

    logic [31:0]        w_off;
    logic               w_is_m, w_is_t, w_is_ctrl, w_is_stat, w_is_vin, w_is_vout, w_sel;
    logic [3:0]         w_m_addr;
    logic [1:0]         w_t_addr;
    logic [IW-1:0]      w_vin_addr, w_vout_addr;
    logic [15:0]        w_bus_in;
    logic [15:0]        w_rd;
    logic               w_cfg_wr;
    logic               w_ctrl_wr;

    logic [1:0]         w_j;
    logic [3:0]         w_mi;
    logic [IW-1:0]      w_vi, w_oi;
    logic signed [15:0] w_mop, w_vop, w_tv;
    logic signed [31:0] w_prod;
    logic signed [35:0] w_prod_x, w_t_x;
    logic [15:0]        w_res;

    // Address decode relative to BASE; anything outside the map stays unselected
    assign w_off       = address - 32'(BASE);
    assign w_is_m      = (w_off < 32'd9);
    assign w_is_t      = (w_off >= 32'd9) && (w_off < 32'd12);
    assign w_is_ctrl   = (w_off == 32'd12);
    assign w_is_stat   = (w_off == 32'd13);
    assign w_is_vin    = (w_off >= VIN_LO) && (w_off < VOUT_LO);
    assign w_is_vout   = (w_off >= VOUT_LO) && (w_off < VOUT_HI);
    assign w_sel       = w_is_m | w_is_t | w_is_ctrl | w_is_stat | w_is_vin | w_is_vout;
    assign w_m_addr    = w_off[3:0];
    assign w_t_addr    = 2'(w_off - 32'd9);
    assign w_vin_addr  = IW'(w_off - VIN_LO);
    assign w_vout_addr = IW'(w_off - VOUT_LO);
    assign w_bus_in    = BUS;
    assign w_cfg_wr    = writeEn && !r_busy;
    assign w_ctrl_wr   = writeEn && w_is_ctrl;

    // The tristate driver is held off during reset so the bus is released immediately
    assign BUS = (w_sel && outputEn && !reset) ? r_rdata : 16'hzzzz;
    assign irq = r_done;

    // Column of M / component of v consumed by the current accumulate step
    always_comb begin
        w_j = 2'd0;
        case (r_state)
            S_ACC1:  w_j = 2'd1;
            S_ACC2:  w_j = 2'd2;
            default: w_j = 2'd0;
        endcase
    end

    assign w_mi     = {2'd0, r_comp} * 4'd3 + {2'd0, w_j};
    assign w_vi     = IW'({2'd0, r_vert} * 10'd3 + {8'd0, w_j});
    assign w_oi     = IW'({2'd0, r_vert} * 10'd3 + {8'd0, r_comp});
    assign w_mop    = r_m[w_mi];
    assign w_vop    = r_vin[w_vi];
    assign w_tv     = r_t[r_comp];
    assign w_prod   = w_mop * w_vop;
    assign w_prod_x = {{4{w_prod[31]}}, w_prod};
    assign w_t_x    = {{20{w_tv[15]}}, w_tv} <<< FRAC_BITS;

`ifdef SATURATE_EN
    logic signed [35:0] w_shift;
    assign w_shift = r_acc >>> FRAC_BITS;

    // Clamp the rescaled result into the signed 16-bit range
    always_comb begin
        if (w_shift > 36'sd32767)
            w_res = 16'h7FFF;
        else if (w_shift < -36'sd32768)
            w_res = 16'h8000;
        else
            w_res = w_shift[15:0];
    end
`else
    // Rescale and keep the low 16 bits; out-of-range results wrap
    assign w_res = 16'(r_acc >>> FRAC_BITS);
`endif

    // Read mux for the registered read buffer; CTRL and unmapped offsets read 0
    always_comb begin
        w_rd = 16'h0000;
        if (w_is_m)
            w_rd = r_m[w_m_addr];
        else if (w_is_t)
            w_rd = r_t[w_t_addr];
        else if (w_is_stat)
            w_rd = {r_vert, 6'b0, r_done, r_busy};
        else if (w_is_vin)
            w_rd = r_vin[w_vin_addr];
        else if (w_is_vout)
            w_rd = r_vout[w_vout_addr];
    end

    // Matrix and translation registers, writable only while idle
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) r_m[i] <= 16'h0000;
            for (int i = 0; i < 3; i++) r_t[i] <= 16'h0000;
        end else if (w_cfg_wr) begin
            if (w_is_m) r_m[w_m_addr] <= w_bus_in;
            if (w_is_t) r_t[w_t_addr] <= w_bus_in;
        end
    end

    // Vertex buffers keep their contents across reset; VOUT is written only by the engine
    always_ff @(posedge CLOCK_50) begin
        if (w_cfg_wr && w_is_vin)
            r_vin[w_vin_addr] <= w_bus_in;
        if (!reset && r_state == S_STORE)
            r_vout[w_oi] <= w_res;
    end

    // Read buffer captures the selected word on every edge the address hits the map
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            r_rdata <= 16'h0000;
        else if (w_sel)
            r_rdata <= w_rd;
    end

    // Sequencer: four steps per output component, three components per vertex
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_vert  <= 8'd0;
            r_comp  <= 2'd0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ctrl_wr && w_bus_in[0]) begin
                        r_state <= S_ACC0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_vert  <= 8'd0;
                        r_comp  <= 2'd0;
                    end else if (w_ctrl_wr && w_bus_in[1]) begin
                        r_done  <= 1'b0;
                    end
                end
                S_ACC0: begin
                    r_acc   <= w_t_x + w_prod_x;
                    r_state <= S_ACC1;
                end
                S_ACC1: begin
                    r_acc   <= r_acc + w_prod_x;
                    r_state <= S_ACC2;
                end
                S_ACC2: begin
                    r_acc   <= r_acc + w_prod_x;
                    r_state <= S_STORE;
                end
                S_STORE: begin
                    if (r_comp == 2'd2) begin
                        r_comp <= 2'd0;
                        if (r_vert == 8'(N_VERT - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_vert  <= r_vert + 8'd1;
                            r_state <= S_ACC0;
                        end
                    end else begin
                        r_comp  <= r_comp + 2'd1;
                        r_state <= S_ACC0;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_transform_mmap.sv
// Bench for vertex_transform_mmap: register map, batch timing, reset and bus gating.
// Latency: expects done one cycle after 12*N_VERT busy cycles following the start write.
// Backpressure: none; the bus pull-up makes a released BUS read as all ones.
module tb_vertex_transform_mmap;

    localparam int N     = 4;
    localparam int NW    = 3 * N;
    localparam int VOUT0 = 16 + NW;

    logic        clk = 1'b0;
    logic        reset;
    tri1  [15:0] BUS;
    logic [31:0] address;
    logic        writeEn;
    logic        outputEn;
    logic        irq;
    logic [15:0] drv_dat;
    logic        drv_oe;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last_wr = 0;

    logic [15:0] sm   [9];
    logic [15:0] st   [3];
    logic [15:0] svin [NW];

    typedef struct {
        int          off;
        logic [15:0] wdat;
        logic [15:0] exp;
    } vec_t;
    vec_t vt [9];

    assign BUS = drv_oe ? drv_dat : 16'hzzzz;

    vertex_transform_mmap dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .BUS      (BUS),
        .address  (address),
        .writeEn  (writeEn),
        .outputEn (outputEn),
        .irq      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic bus_write(input int off, input logic [15:0] d);
        @(negedge clk);
        address = 32'(off);
        writeEn = 1'b1;
        drv_oe  = 1'b1;
        drv_dat = d;
        @(posedge clk); #1;
        last_wr = cyc;
        writeEn = 1'b0;
        drv_oe  = 1'b0;
    endtask

    task automatic bus_read(input int off, output logic [15:0] d);
        @(negedge clk);
        address  = 32'(off);
        outputEn = 1'b1;
        @(posedge clk); #1;
        d = BUS;
        outputEn = 1'b0;
    endtask

    task automatic check_z(input string name, input int off, input logic oe);
        @(negedge clk);
        address  = 32'(off);
        outputEn = oe;
        @(posedge clk); #1;
        check(name, BUS, 16'hFFFF);
        outputEn = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // Reference: exact integer evaluation of M*v + t, then floor-rescale
    function automatic logic [15:0] model(input int vtx, input int c);
        longint acc;
        longint sh;
        acc = 256 * longint'($signed(st[c]));
        for (int j = 0; j < 3; j++)
            acc += longint'($signed(sm[3*c+j])) * longint'($signed(svin[3*vtx+j]));
        sh = acc >>> 8;
`ifdef SATURATE_EN
        if (sh > 32767) sh = 32767;
        else if (sh < -32768) sh = -32768;
`endif
        return 16'(sh);
    endfunction

    task automatic load_all();
        for (int i = 0; i < 9; i++)  bus_write(i, sm[i]);
        for (int i = 0; i < 3; i++)  bus_write(9 + i, st[i]);
        for (int i = 0; i < NW; i++) bus_write(16 + i, svin[i]);
    endtask

    task automatic randomize_all();
        for (int i = 0; i < 9; i++)  sm[i]   = 16'($urandom);
        for (int i = 0; i < 3; i++)  st[i]   = 16'($urandom);
        for (int i = 0; i < NW; i++) svin[i] = 16'($urandom);
    endtask

    task automatic set_diag(input logic [15:0] d);
        for (int i = 0; i < 9; i++) sm[i] = (i % 4 == 0) ? d : 16'h0000;
    endtask

    task automatic finish_batch(input string tag, input int k);
        wait_cyc(k + 48);
        check($sformatf("%s irq_at_k+48", tag), {15'd0, irq}, 16'd0);
        wait_cyc(k + 49);
        check($sformatf("%s irq_at_k+49", tag), {15'd0, irq}, 16'd1);
    endtask

    task automatic check_vout(input string tag);
        logic [15:0] d;
        for (int i = 0; i < NW; i++) begin
            bus_read(VOUT0 + i, d);
            check($sformatf("%s vout%0d", tag, i), d, model(i / 3, i % 3));
        end
    endtask

    initial begin
        logic [15:0] d;
        int k;

        vt[0] = '{0,  16'h0100, 16'h0100};
        vt[1] = '{4,  16'hABCD, 16'hABCD};
        vt[2] = '{8,  16'h8001, 16'h8001};
        vt[3] = '{9,  16'h1234, 16'h1234};
        vt[4] = '{11, 16'hFFFF, 16'hFFFF};
        vt[5] = '{12, 16'h0000, 16'h0000};
        vt[6] = '{13, 16'hFFFF, 16'h0000};
        vt[7] = '{16, 16'h5A5A, 16'h5A5A};
        vt[8] = '{27, 16'h0F0F, 16'h0F0F};

        reset    = 1'b1;
        address  = 32'd13;
        writeEn  = 1'b0;
        outputEn = 1'b1;
        drv_oe   = 1'b0;
        drv_dat  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("bus_z_in_reset", BUS, 16'hFFFF);
        check("irq_reset", {15'd0, irq}, 16'd0);
        @(negedge clk);
        reset    = 1'b0;
        outputEn = 1'b0;

        bus_read(13, d); check("status_reset", d, 16'h0000);
        bus_read(0, d);  check("m0_reset", d, 16'h0000);
        bus_read(11, d); check("tz_reset", d, 16'h0000);

        for (int i = 0; i < 9; i++) begin
            bus_write(vt[i].off, vt[i].wdat);
            bus_read(vt[i].off, d);
            check($sformatf("map_off%0d", vt[i].off), d, vt[i].exp);
        end

        check_z("z_status_oe0", 13, 1'b0);
        check_z("z_off14", 14, 1'b1);
        check_z("z_off40", 40, 1'b1);

        // Identity matrix
        randomize_all();
        set_diag(16'h0100);
        for (int i = 0; i < 3; i++) st[i] = 16'h0000;
        svin[0] = 16'h0200; svin[1] = 16'hFF00; svin[2] = 16'h0080;
        load_all();
        bus_write(12, 16'h0001);
        k = last_wr;
        finish_batch("ident", k);
        bus_read(VOUT0 + 0, d); check("ident x", d, 16'h0200);
        bus_read(VOUT0 + 1, d); check("ident y", d, 16'hFF00);
        bus_read(VOUT0 + 2, d); check("ident z", d, 16'h0080);
        check_vout("ident");
        bus_read(13, d); check("status_done_bits", {14'd0, d[1:0]}, 16'd2);
        bus_write(12, 16'h0002);
        check("irq_after_clear", {15'd0, irq}, 16'd0);

        // Scale by two plus translation
        randomize_all();
        set_diag(16'h0200);
        st[0] = 16'h0100; st[1] = 16'h0000; st[2] = 16'h0000;
        svin[3] = 16'h0100; svin[4] = 16'h0100; svin[5] = 16'h0100;
        load_all();
        bus_write(12, 16'h0001);
        k = last_wr;
        finish_batch("scale", k);
        bus_read(VOUT0 + 3, d); check("scale x", d, 16'h0300);
        bus_read(VOUT0 + 4, d); check("scale y", d, 16'h0200);
        bus_read(VOUT0 + 5, d); check("scale z", d, 16'h0200);
        check_vout("scale");

        // Overflowing product
        randomize_all();
        set_diag(16'h7FFF);
        for (int i = 0; i < 3; i++) st[i] = 16'h0000;
        svin[6] = 16'h7FFF; svin[7] = 16'h0000; svin[8] = 16'h0000;
        load_all();
        bus_write(12, 16'h0001);
        k = last_wr;
        finish_batch("ovf", k);
        bus_read(VOUT0 + 6, d);
`ifdef SATURATE_EN
        check("ovf x", d, 16'h7FFF);
`else
        check("ovf x", d, 16'hFF00);
`endif
        check_vout("ovf");

        // Writes and a second start during a batch are dropped
        randomize_all();
        sm[0] = 16'h4321;
        load_all();
        bus_write(12, 16'h0001);
        k = last_wr;
        wait_cyc(k + 9);
        bus_write(0, 16'h1234);
        bus_write(12, 16'h0001);
        bus_read(13, d); check("status_busy_bits", {14'd0, d[1:0]}, 16'd1);
        finish_batch("busy", k);
        bus_read(0, d); check("m0_unchanged", d, 16'h4321);
        check_vout("busy");

        // Reset in the middle of a batch, then a clean batch
        randomize_all();
        load_all();
        bus_write(12, 16'h0001);
        k = last_wr;
        wait_cyc(k + 19);
        @(negedge clk);
        reset    = 1'b1;
        address  = 32'd13;
        outputEn = 1'b1;
        @(posedge clk); #1;
        check("midrst irq", {15'd0, irq}, 16'd0);
        check("midrst bus_z", BUS, 16'hFFFF);
        @(negedge clk);
        reset    = 1'b0;
        outputEn = 1'b0;
        bus_read(13, d); check("midrst status", d, 16'h0000);
        bus_read(0, d);  check("midrst m0", d, 16'h0000);
        randomize_all();
        load_all();
        bus_write(12, 16'h0001);
        k = last_wr;
        finish_batch("after_rst", k);
        check_vout("after_rst");

        // Random batches; the first starts with clear-done in the same write
        for (int b = 0; b < 2; b++) begin
            randomize_all();
            load_all();
            bus_write(12, (b == 0) ? 16'h0003 : 16'h0001);
            k = last_wr;
            if (b == 0) check("start_and_clear irq", {15'd0, irq}, 16'd0);
            finish_batch($sformatf("rand%0d", b), k);
            check_vout($sformatf("rand%0d", b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
